alu_sweep_ctrl: RTL and testbench
=================================

# alu_sweep_ctrl

Sequencer that drives the ALU/7-segment top with every (opcode, opa, opb) combination in a fixed order. Each vector is held for a programmable number of clock cycles so the displays and checkers can observe it. Runs single-pass or looping, and supports pause, single-step and abort. Sits in front of the ALU top and replaces manual switch stimulus on the board and in system benches.

## Interface
- DATA_WIDTH, 3, width of opa/opb
- OPCODE_WIDTH, 2, width of opcode
- DWELL_WIDTH, 8, width of the dwell-time input and counter
- PASS_WIDTH, 8, width of the completed-pass counter
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; honoured only in IDLE
- loop  input  1  sampled at start; 1 = wrap to vector 0 after the last vector, 0 = single pass
- dwell_cycles  input  DWELL_WIDTH  cycles per vector; sampled at start; 0 is treated as 1
- pause  input  1  level; freezes the sweep while high
- step  input  1  in PAUSE, advance one vector per cycle high
- abort  input  1  return to IDLE from any state; no done pulse
- opcode  output  OPCODE_WIDTH  current opcode to the ALU
- opa  output  DATA_WIDTH  current operand A
- opb  output  DATA_WIDTH  current operand B
- valid  output  1  vector outputs are meaningful
- vec_stb  output  1  one-cycle pulse when a new vector is presented
- busy  output  1  high in RUN and PAUSE
- done  output  1  one-cycle pulse at the end of a single pass
- pass_cnt  output  PASS_WIDTH  completed passes since start; saturating

## Operation
- States:
  - IDLE: waits for start.
  - RUN: dwell counting.
  - PAUSE: frozen; step allowed.
  - DONE: one cycle, then IDLE.
- Vector order: opb is the fastest field, then opa, then opcode. All fields sweep 0 to max inclusive, giving 2^(OPCODE_WIDTH+2·DATA_WIDTH) vectors (256 at defaults).
- Advance rule:
  - opb increments.
  - When opb wraps 7→0, opa increments.
  - When opa wraps, opcode increments.
  - The last vector is all-ones.
- IDLE + start:
  - Load D = max(dwell_cycles, 1) and loop_q = loop.
  - Clear the dwell counter and pass_cnt.
  - Vector ← 0; valid=1, vec_stb=1, busy=1; go to RUN.
- RUN:
  - The dwell counter increments each cycle.
  - When it reaches D-1: clear it and advance, with vec_stb=1.
  - Advance from the last vector with loop_q=1: vector ← 0, pass_cnt +1 (saturating at all-ones).
  - Advance from the last vector with loop_q=0: go to DONE; pass_cnt +1.
- RUN + pause=1: go to PAUSE on the next edge. The dwell counter is frozen; outputs hold; valid stays 1.
- PAUSE:
  - step=1 advances immediately, using the same rules as RUN, and clears the dwell counter.
  - pause=0 returns to RUN; dwell counting resumes from the frozen count, or from 0 after a step.
- DONE: done=1, valid=0, busy=0; vector holds its last value; next state IDLE.
- Priority: abort > pause/step > dwell advance.
  - abort: next state IDLE; valid, busy and vec_stb drop; vector holds its value.
  - start outside IDLE is ignored.
  - step in RUN is ignored.
  - pause in IDLE is ignored.
- Reset (asynchronous, any time including mid-sweep):
  - State IDLE.
  - opcode, opa, opb, valid, vec_stb, busy, done, pass_cnt all 0.
  - Dwell counter 0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- start high at edge k: after edge k, vector 0, valid=1, vec_stb=1.
- Each vector is held exactly D cycles in RUN, so vec_stb pulses every D cycles.
- Single pass, no pause: the last vector appears after edge k+(N-1)·D. done=1 after edge k+N·D for exactly one cycle (N = vector count).
- pause high at edge p: the value seen at edge p is the last count in RUN. A dwell expiry coinciding with edge p is suppressed; pause wins.
- step at edge s in PAUSE: the new vector and vec_stb appear after edge s. With step held high, the sweep advances one vector per cycle.
- abort at edge a: IDLE after edge a. start may be accepted at edge a+1.

## Test plan
- Reset then idle 5 cycles:
  - All outputs are 0.
  - start with rstn=0 has no effect.
- dwell_cycles=1, loop=0, start at edge k:
  - 256 consecutive vectors (0,0,0)…(3,7,7), with vec_stb high on each.
  - done pulses once after edge k+256.
  - valid=0 afterwards; pass_cnt=1.
- dwell_cycles=3:
  - (0,0,1) appears 3 cycles after (0,0,0).
  - (0,1,0) follows (0,0,7) after 3 cycles.
  - (1,0,0) follows (0,7,7).
  - dwell_cycles=0 gives 1-cycle spacing.
- pause on the 2nd cycle of (1,2,5) with D=3:
  - The vector holds for 10 cycles.
  - Three step pulses give (1,2,6), (1,2,7), (1,3,0).
  - After pause drops, (1,3,1) appears after 3 cycles.
- loop=1, D=1:
  - (3,7,7) is followed by (0,0,0); pass_cnt=1, no done.
  - After 2 passes, pass_cnt=2.
  - abort mid-pass: busy=0, valid=0, no done.
- Corner cases:
  - start while busy: ignored; sweep unchanged.
  - rstn low mid-sweep at (2,4,3): all outputs 0 immediately.
  - A new start runs from (0,0,0).

Source files
------------

// File: rtl/alu_sweep_ctrl.sv
// Steps the ALU top through every (opcode, opa, opb) vector, holding each for a sampled dwell time.
// All outputs are registered; single-pass or looping, with pause, single-step and abort.
module alu_sweep_ctrl #(
   parameter int DATA_WIDTH   = 3,
   parameter int OPCODE_WIDTH = 2,
   parameter int DWELL_WIDTH  = 8,
   parameter int PASS_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic                    loop,
   input  logic [DWELL_WIDTH-1:0]  dwell_cycles,
   input  logic                    pause,
   input  logic                    step,
   input  logic                    abort,
   output logic [OPCODE_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0]   opa,
   output logic [DATA_WIDTH-1:0]   opb,
   output logic                    valid,
   output logic                    vec_stb,
   output logic                    busy,
   output logic                    done,
   output logic [PASS_WIDTH-1:0]   pass_cnt
);
   localparam int VEC_WIDTH = OPCODE_WIDTH + 2*DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t                 state;
   logic [VEC_WIDTH-1:0]   vec;
   logic [DWELL_WIDTH-1:0] dwell_cnt;
   logic [DWELL_WIDTH-1:0] dwell_len;
   logic                   loop_q;
   logic                   last_vec;
   logic                   expire;
   logic                   advance;

   // opb occupies the low bits so a plain increment gives the opb/opa/opcode carry order
   assign {opcode, opa, opb} = vec;
   assign last_vec = &vec;
   assign expire   = (dwell_cnt == dwell_len - DWELL_WIDTH'(1));
   assign advance  = !abort && (((state == S_RUN) && !pause && expire) ||
                                ((state == S_PAUSE) && step));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         vec       <= '0;
         dwell_cnt <= '0;
         dwell_len <= DWELL_WIDTH'(1);
         loop_q    <= 1'b0;
         valid     <= 1'b0;
         vec_stb   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass_cnt  <= '0;
      end else begin
         vec_stb <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state     <= S_RUN;
                  dwell_len <= (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;
                  loop_q    <= loop;
                  dwell_cnt <= '0;
                  pass_cnt  <= '0;
                  vec       <= '0;
                  valid     <= 1'b1;
                  vec_stb   <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            S_RUN, S_PAUSE: begin
               if (abort) begin
                  state <= S_IDLE;
                  valid <= 1'b0;
                  busy  <= 1'b0;
               end else if (advance) begin
                  dwell_cnt <= '0;
                  if (last_vec && (pass_cnt != {PASS_WIDTH{1'b1}}))
                     pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                  if (last_vec && !loop_q) begin
                     state <= S_DONE;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     // a step taken with pause already released resumes RUN with a fresh dwell
                     state   <= pause ? S_PAUSE : S_RUN;
                     vec     <= vec + VEC_WIDTH'(1);
                     vec_stb <= 1'b1;
                  end
               end else if (pause) begin
                  state <= S_PAUSE;
               end else if (state == S_PAUSE) begin
                  state <= S_RUN;
               end else begin
                  dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl: a per-cycle vector table, then hand sequences for
// full sweeps, dwell spacing, pause/step, looping, abort and mid-sweep reset.
module tb_alu_sweep_ctrl;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic       loop = 1'b0;
   logic [7:0] dwell_cycles = 8'd0;
   logic       pause = 1'b0;
   logic       step = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] opcode;
   logic [2:0] opa;
   logic [2:0] opb;
   logic       valid;
   logic       vec_stb;
   logic       busy;
   logic       done;
   logic [7:0] pass_cnt;
   logic [7:0] cur;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   alu_sweep_ctrl dut (
      .clk(clk), .rstn(rstn), .start(start), .loop(loop), .dwell_cycles(dwell_cycles),
      .pause(pause), .step(step), .abort(abort), .opcode(opcode), .opa(opa), .opb(opb),
      .valid(valid), .vec_stb(vec_stb), .busy(busy), .done(done), .pass_cnt(pass_cnt)
   );

   assign cur = {opcode, opa, opb};

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   typedef struct packed {
      logic       rstn, start, loop;
      logic [7:0] dwell;
      logic       pause, step, abort;
      logic [7:0] e_vec;
      logic       e_valid, e_stb, e_busy, e_done;
      logic [7:0] e_pass;
   } row_t;

   row_t tbl [15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_stb(input int budget, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (vec_stb !== 1'b1 && cycles < budget);
      if (vec_stb !== 1'b1) check("next_stb_timeout", 32'(vec_stb), 32'd1);
   endtask

   task automatic wait_vec(input logic [7:0] target, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(cur === target && vec_stb === 1'b1) && n < budget);
      check($sformatf("reach_%02h", target), 32'(cur), 32'(target));
   endtask

   initial begin
      int cyc;
      int errs;
      int dstart;

      // rstn start loop dwell pause step abort | vec valid stb busy done pass
      tbl[0]  = '{1'b0,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[1]  = '{1'b0,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[2]  = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[3]  = '{1'b1,1'b0,1'b0,8'd0,1'b1,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[4]  = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b1,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[5]  = '{1'b1,1'b1,1'b0,8'd2,1'b0,1'b0,1'b0, 8'h00,1'b1,1'b1,1'b1,1'b0,8'd0};
      tbl[6]  = '{1'b1,1'b0,1'b0,8'd2,1'b0,1'b1,1'b0, 8'h00,1'b1,1'b0,1'b1,1'b0,8'd0};
      tbl[7]  = '{1'b1,1'b0,1'b0,8'd2,1'b0,1'b0,1'b0, 8'h01,1'b1,1'b1,1'b1,1'b0,8'd0};
      tbl[8]  = '{1'b1,1'b1,1'b0,8'd1,1'b0,1'b0,1'b0, 8'h01,1'b1,1'b0,1'b1,1'b0,8'd0};
      tbl[9]  = '{1'b1,1'b0,1'b0,8'd1,1'b0,1'b0,1'b0, 8'h02,1'b1,1'b1,1'b1,1'b0,8'd0};
      tbl[10] = '{1'b1,1'b0,1'b0,8'd1,1'b0,1'b0,1'b1, 8'h02,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[11] = '{1'b1,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 8'h00,1'b1,1'b1,1'b1,1'b0,8'd0};
      tbl[12] = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 8'h01,1'b1,1'b1,1'b1,1'b0,8'd0};
      tbl[13] = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,1'b1, 8'h01,1'b0,1'b0,1'b0,1'b0,8'd0};
      tbl[14] = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 8'h01,1'b0,1'b0,1'b0,1'b0,8'd0};

      for (int i = 0; i < 15; i++) begin
         rstn = tbl[i].rstn; start = tbl[i].start; loop = tbl[i].loop;
         dwell_cycles = tbl[i].dwell; pause = tbl[i].pause; step = tbl[i].step;
         abort = tbl[i].abort;
         tick();
         check($sformatf("row%0d", i), 32'({cur, valid, vec_stb, busy, done, pass_cnt}),
               32'({tbl[i].e_vec, tbl[i].e_valid, tbl[i].e_stb, tbl[i].e_busy,
                    tbl[i].e_done, tbl[i].e_pass}));
      end
      start = 0; pause = 0; step = 0; abort = 0;
      tick();

      // full single pass at one cycle per vector
      dwell_cycles = 8'd1; loop = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      dstart = done_cnt;
      errs = 0;
      for (int i = 0; i < 256; i++) begin
         if (cur !== i[7:0] || vec_stb !== 1'b1 || valid !== 1'b1 || done !== 1'b0) errs++;
         if (i < 255) tick();
      end
      check("d1_sweep_errs", 32'(errs), 32'd0);
      tick();
      check("d1_done", 32'(done), 32'd1);
      check("d1_valid_busy_after", 32'({valid, busy}), 32'd0);
      check("d1_pass_cnt", 32'(pass_cnt), 32'd1);
      check("d1_vec_hold", 32'(cur), 32'hFF);
      tick();
      check("d1_done_once", 32'(done_cnt - dstart), 32'd1);
      check("d1_done_low", 32'(done), 32'd0);

      // dwell of 3 with carries, then pause/step on (1,2,5)
      dwell_cycles = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      check("d3_first", 32'(cur), 32'h00);
      next_stb(10, cyc);
      check("d3_vec1", 32'(cur), 32'h01);
      check("d3_spacing", 32'(cyc), 32'd3);
      wait_vec(8'h07, 100);
      next_stb(10, cyc);
      check("d3_opa_carry", 32'(cur), 32'h08);
      check("d3_opa_spacing", 32'(cyc), 32'd3);
      wait_vec(8'h3F, 500);
      next_stb(10, cyc);
      check("d3_opcode_carry", 32'(cur), 32'h40);
      check("d3_opcode_spacing", 32'(cyc), 32'd3);
      wait_vec(8'h55, 200);
      tick();
      pause = 1'b1;
      errs = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cur !== 8'h55 || vec_stb !== 1'b0 || valid !== 1'b1 || busy !== 1'b1) errs++;
      end
      check("pause_hold_errs", 32'(errs), 32'd0);
      step = 1'b1;
      tick();
      check("step1", 32'({cur, vec_stb}), 32'({8'h56, 1'b1}));
      step = 1'b0;
      tick();
      check("step_gap", 32'({cur, vec_stb}), 32'({8'h56, 1'b0}));
      step = 1'b1;
      tick();
      check("step2", 32'({cur, vec_stb}), 32'({8'h57, 1'b1}));
      pause = 1'b0;
      tick();
      check("step3", 32'({cur, vec_stb, busy}), 32'({8'h58, 1'b1, 1'b1}));
      step = 1'b0;
      next_stb(10, cyc);
      check("resume_vec", 32'(cur), 32'h59);
      check("resume_spacing", 32'(cyc), 32'd3);

      // start while busy must not restart nor change dwell
      dwell_cycles = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_ignored", 32'({cur, vec_stb}), 32'({8'h59, 1'b0}));
      next_stb(10, cyc);
      check("busy_start_next", 32'(cur), 32'h5A);
      check("busy_start_spacing", 32'(cyc), 32'd2);

      // asynchronous reset in the middle of the sweep
      wait_vec(8'hA3, 1000);
      rstn = 1'b0;
      #1;
      check("async_reset", 32'({cur, valid, vec_stb, busy, done, pass_cnt}), 32'd0);
      tick();
      rstn = 1'b1;
      dwell_cycles = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_vec0", 32'({cur, vec_stb, valid}), 32'({8'h00, 1'b1, 1'b1}));
      next_stb(10, cyc);
      check("dwell0_spacing", 32'({cur, 8'(cyc)}), 32'({8'h01, 8'd1}));
      next_stb(10, cyc);
      check("dwell0_spacing2", 32'({cur, 8'(cyc)}), 32'({8'h02, 8'd1}));
      dstart = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_outputs", 32'({cur, valid, vec_stb, busy, done}), 32'({8'h02, 4'b0000}));
      tick();
      tick();
      check("abort_no_done", 32'(done_cnt - dstart), 32'd0);

      // looping sweep
      loop = 1'b1; dwell_cycles = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      dstart = done_cnt;
      wait_vec(8'hFF, 300);
      tick();
      check("loop_wrap", 32'({cur, vec_stb, valid, busy, done}), 32'({8'h00, 4'b1110}));
      check("loop_pass1", 32'(pass_cnt), 32'd1);
      wait_vec(8'hFF, 300);
      tick();
      check("loop_pass2", 32'({cur, pass_cnt}), 32'({8'h00, 8'd2}));
      repeat (40) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("loop_abort", 32'({valid, busy, vec_stb}), 32'd0);
      tick();
      check("loop_no_done", 32'(done_cnt - dstart), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
